// File: rtl/uart_frame_sequencer.sv
// UART command frame sequencer: parses 7E/CMD/LEN/PAYLOAD/CHK frames
// and drives either the serial shift register or the LED register.
module uart_frame_sequencer #(
  parameter int SHIFT_DIV = 4,
  parameter int MAX_LEN   = 8,
  parameter int TIMEOUT   = 34720
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       sr_data,
  output logic       sr_shift,
  output logic       sr_latch,
  output logic [7:0] led,
  output logic       busy,
  output logic       frame_ok,
  output logic       err_pulse,
  output logic [2:0] err_code
);

  localparam int DW = $clog2(SHIFT_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] MAXL = 8'(MAX_LEN);
  localparam logic [DW-1:0] DIV_LAST = DW'(SHIFT_DIV - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] E_TIMEOUT = 3'd1;
  localparam logic [2:0] E_CHKSUM  = 3'd2;
  localparam logic [2:0] E_BADCMD  = 3'd3;
  localparam logic [2:0] E_BADLEN  = 3'd4;
  localparam logic [2:0] E_OVERRUN = 3'd5;

  typedef enum logic [2:0] {
    HUNT,
    CMD,
    LEN,
    PAYLOAD,
    CHK,
    EXEC_SHIFT,
    EXEC_LATCH
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    cmd_q;
  logic [3:0]    len_q;
  logic [3:0]    cnt_q;
  logic [7:0]    sum_q;
  logic [7:0]    buf_q [8];
  logic [TW-1:0] tcnt_q;
  logic [DW-1:0] div_q;
  logic [2:0]    bit_q;
  logic [3:0]    byte_q;
  logic [7:0]    led_q;
  logic          frame_q;
  logic          err_q;
  logic [2:0]    code_q;

  logic       in_frame;
  logic       tout;
  logic       bit_end;
  logic       last_bit;
  logic [7:0] sum_next;
  logic       err_set;
  logic [2:0] err_val;
  logic       led_load;
  logic       shift_start;

  assign in_frame = (state_q == CMD) || (state_q == LEN) ||
                    (state_q == PAYLOAD) || (state_q == CHK);
  assign tout     = in_frame && !rx_valid && (tcnt_q == T_LAST);
  assign bit_end  = (div_q == DIV_LAST);
  assign last_bit = bit_end && (bit_q == 3'd0) &&
                    (byte_q == len_q - 4'd1);
  assign sum_next = sum_q + rx_data;

  // State register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state_q <= HUNT;
    else        state_q <= state_d;
  end

  // Next-state decode and error classification
  always_comb begin
    state_d     = state_q;
    err_set     = 1'b0;
    err_val     = 3'd0;
    led_load    = 1'b0;
    shift_start = 1'b0;
    case (state_q)
      HUNT: begin
        if (rx_valid && rx_data == 8'h7E) state_d = CMD;
      end
      CMD: begin
        if (rx_valid) begin
          if (rx_data == 8'h01 || rx_data == 8'h02) begin
            state_d = LEN;
          end else begin
            err_set = 1'b1;
            err_val = E_BADCMD;
            state_d = HUNT;
          end
        end
      end
      LEN: begin
        if (rx_valid) begin
          if (rx_data != 8'h00 && rx_data <= MAXL) begin
            state_d = PAYLOAD;
          end else begin
            err_set = 1'b1;
            err_val = E_BADLEN;
            state_d = HUNT;
          end
        end
      end
      PAYLOAD: begin
        if (rx_valid && cnt_q == len_q - 4'd1) state_d = CHK;
      end
      CHK: begin
        if (rx_valid) begin
          if (sum_next != 8'h00) begin
            err_set = 1'b1;
            err_val = E_CHKSUM;
            state_d = HUNT;
          end else if (cmd_q == 8'h02) begin
            led_load = 1'b1;
            state_d  = HUNT;
          end else begin
            shift_start = 1'b1;
            state_d     = EXEC_SHIFT;
          end
        end
      end
      EXEC_SHIFT: begin
        if (last_bit) state_d = EXEC_LATCH;
        if (rx_valid) begin
          err_set = 1'b1;
          err_val = E_OVERRUN;
        end
      end
      EXEC_LATCH: begin
        state_d = HUNT;
        if (rx_valid) begin
          err_set = 1'b1;
          err_val = E_OVERRUN;
        end
      end
      default: state_d = HUNT;
    endcase
    if (tout) begin
      err_set = 1'b1;
      err_val = E_TIMEOUT;
      state_d = HUNT;
    end
  end

  // Frame capture: command, length, payload buffer and running sum
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cmd_q <= 8'h00;
      len_q <= 4'd0;
      cnt_q <= 4'd0;
      sum_q <= 8'h00;
      for (int i = 0; i < 8; i++) buf_q[i] <= 8'h00;
    end else if (rx_valid) begin
      case (state_q)
        CMD: begin
          cmd_q <= rx_data;
          sum_q <= rx_data;
        end
        LEN: begin
          len_q <= rx_data[3:0];
          sum_q <= sum_next;
          cnt_q <= 4'd0;
        end
        PAYLOAD: begin
          buf_q[cnt_q[2:0]] <= rx_data;
          sum_q <= sum_next;
          cnt_q <= cnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Inter-byte idle counter, restarted by every received byte
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) tcnt_q <= '0;
    else if (in_frame && !rx_valid && !tout) tcnt_q <= tcnt_q + 1'b1;
    else tcnt_q <= '0;
  end

  // Serialiser position: bit divider, bit index, byte index
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      bit_q  <= 3'd7;
      byte_q <= 4'd0;
    end else if (shift_start) begin
      div_q  <= '0;
      bit_q  <= 3'd7;
      byte_q <= 4'd0;
    end else if (state_q == EXEC_SHIFT) begin
      if (bit_end) begin
        div_q <= '0;
        bit_q <= bit_q - 3'd1;
        if (bit_q == 3'd0) byte_q <= byte_q + 4'd1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  // LED register, accept pulse and error reporting
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      led_q   <= 8'h00;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
    end else begin
      if (led_load) led_q <= buf_q[0];
      frame_q <= led_load;
      err_q   <= err_set;
      if (err_set) code_q <= err_val;
    end
  end

  assign sr_data   = (state_q == EXEC_SHIFT) ?
                     buf_q[byte_q[2:0]][bit_q] : 1'b0;
  assign sr_shift  = (state_q == EXEC_SHIFT) && bit_end;
  assign sr_latch  = (state_q == EXEC_LATCH);
  assign busy      = (state_q == EXEC_SHIFT) ||
                     (state_q == EXEC_LATCH);
  assign frame_ok  = frame_q || (state_q == EXEC_LATCH);
  assign led       = led_q;
  assign err_pulse = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Directed self-checking bench for uart_frame_sequencer.
// Frames, shift patterns and error codes are hand-computed below.
module tb_uart_frame_sequencer;

  localparam int SDIV = 4;
  localparam int MLEN = 8;
  localparam int TOUT = 34720;

  logic       CLK = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       sr_data;
  logic       sr_shift;
  logic       sr_latch;
  logic [7:0] led;
  logic       busy;
  logic       frame_ok;
  logic       err_pulse;
  logic [2:0] err_code;

  int n_checks = 0;
  int n_fail   = 0;

  uart_frame_sequencer #(
    .SHIFT_DIV(SDIV),
    .MAX_LEN(MLEN),
    .TIMEOUT(TOUT)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .sr_data(sr_data),
    .sr_shift(sr_shift),
    .sr_latch(sr_latch),
    .led(led),
    .busy(busy),
    .frame_ok(frame_ok),
    .err_pulse(err_pulse),
    .err_code(err_code)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Follows a shift run from its first bit to the latch cycle.
  // inj >= 0 injects a byte at that cycle offset.
  task automatic run_shift(input logic [15:0] pat, input int nbits,
                           input int inj);
    int shifts;
    logic exp_bit;
    shifts = 0;
    for (int i = 0; i < nbits * SDIV; i++) begin
      exp_bit = pat[nbits - 1 - i / SDIV];
      check("sr_data", sr_data, exp_bit);
      check("sr_shift", sr_shift, (i % SDIV) == SDIV - 1);
      check("busy_shift", busy, 1);
      check("no_latch", sr_latch, 0);
      if (sr_shift) shifts++;
      if (i == inj) begin
        rx_data  = 8'h7E;
        rx_valid = 1'b1;
      end
      tick();
      rx_valid = 1'b0;
      if (i == inj) begin
        check("ovr_pulse", err_pulse, 1);
        check("ovr_code", err_code, 5);
      end
    end
    check("shift_count", shifts, nbits);
    check("latch", sr_latch, 1);
    check("latch_ok", frame_ok, 1);
    check("latch_busy", busy, 1);
    check("latch_data", sr_data, 0);
    tick();
    check("idle_busy", busy, 0);
    check("idle_latch", sr_latch, 0);
    check("idle_ok", frame_ok, 0);
  endtask

  initial begin
    int cnt;
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_led", led, 8'h00);
    check("rst_code", err_code, 0);
    check("rst_busy", busy, 0);
    check("rst_sr", {sr_data, sr_shift, sr_latch}, 0);
    check("rst_ok", {frame_ok, err_pulse}, 0);
    reset = 1'b1;
    tick();

    // Shift frame A5, one byte
    send(8'h7E); send(8'h01); send(8'h01); send(8'hA5); send(8'h59);
    run_shift(16'h00A5, 8, -1);
    check("shift_led", led, 8'h00);

    // Leading junk, then LED frame
    send(8'hF4); send(8'h7E); send(8'h02); send(8'h01); send(8'h3C);
    send(8'hC1);
    check("led_3c", led, 8'h3C);
    check("led_ok", frame_ok, 1);
    check("led_noshift", sr_shift, 0);
    check("led_busy", busy, 0);
    tick();
    check("led_ok_clr", frame_ok, 0);

    // Bad checksum
    send(8'h7E); send(8'h02); send(8'h01); send(8'h3C); send(8'hC2);
    check("chk_pulse", err_pulse, 1);
    check("chk_code", err_code, 2);
    check("chk_led", led, 8'h3C);
    check("chk_ok", frame_ok, 0);
    tick();
    check("chk_pulse_clr", err_pulse, 0);
    send(8'h7E); send(8'h02); send(8'h01); send(8'h55); send(8'hA8);
    check("led_55", led, 8'h55);

    // Bad command, zero length, oversize length
    send(8'h7E); send(8'h03);
    check("cmd_pulse", err_pulse, 1);
    check("cmd_code", err_code, 3);
    send(8'h7E); send(8'h01); send(8'h00);
    check("len0_pulse", err_pulse, 1);
    check("len0_code", err_code, 4);
    tick();
    send(8'h7E); send(8'h01); send(8'h09);
    check("len9_pulse", err_pulse, 1);
    check("len9_code", err_code, 4);

    // Maximum-length LED frame: only the first byte reaches the LEDs
    send(8'h7E); send(8'h02); send(8'h08);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    send(8'h92);
    check("max_led", led, 8'h11);
    check("max_ok", frame_ok, 1);

    // Byte arriving on the last allowed idle cycle is accepted
    send(8'h7E); send(8'h02); send(8'h01);
    repeat (TOUT - 1) tick();
    send(8'h0F);
    check("edge_nopulse", err_pulse, 0);
    send(8'hEE);
    check("edge_led", led, 8'h0F);
    check("edge_code", err_code, 4);

    // Stall inside a frame
    send(8'h7E); send(8'h01); send(8'h02); send(8'hFF);
    repeat (TOUT - 1) tick();
    check("to_early", err_pulse, 0);
    tick();
    check("to_pulse", err_pulse, 1);
    check("to_code", err_code, 1);
    send(8'h7E); send(8'h02); send(8'h01); send(8'hA0); send(8'h5D);
    check("to_led", led, 8'hA0);

    // Overrun during a two-byte shift
    send(8'h7E); send(8'h01); send(8'h02); send(8'h7E); send(8'h7E);
    send(8'h01);
    run_shift(16'h7E7E, 16, 5 * SDIV);
    check("ovr_code_end", err_code, 5);
    send(8'h02); send(8'h01); send(8'h33); send(8'hCA);
    check("ovr_led", led, 8'hA0);
    check("ovr_ok", frame_ok, 0);

    // Reset in the middle of a shift
    send(8'h7E); send(8'h01); send(8'h01); send(8'hA5); send(8'h59);
    repeat (3 * SDIV) tick();
    check("mid_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_sr", {sr_data, sr_shift, sr_latch}, 0);
    check("arst_led", led, 8'h00);
    check("arst_code", err_code, 0);
    check("arst_ok", {frame_ok, err_pulse}, 0);
    tick();
    tick();
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (sr_latch || sr_shift || busy) cnt++;
      tick();
    end
    check("arst_quiet", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
